// File: rtl/dmem_bridge.sv
// Load/store bridge between the core data port and a handshaked data-memory bus.
// Steers byte lanes, extends loads, and stalls the core while an access is outstanding.
module dmem_bridge #(
  parameter int WORD    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic [1:0]      size,
  input  logic            unsignedLd,
  input  logic [WORD-1:0] addr,
  input  logic [WORD-1:0] writeData,
  output logic [WORD-1:0] readData,
  output logic            stall,
  output logic            misaligned,
  output logic            timeout,
  output logic            bus_req,
  output logic            bus_we,
  output logic [WORD-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [WORD-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [WORD-1:0] bus_rdata,
  output logic [1:0]      o_dbg_state
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_bus_req;
  logic            r_bus_we;
  logic [WORD-1:0] r_bus_addr;
  logic [3:0]      r_bus_be;
  logic [WORD-1:0] r_bus_wdata;
  logic [WORD-1:0] r_read_data;
  logic            r_timeout;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_lo;
  logic [1:0]      r_size;
  logic            r_uns;

  logic            w_req;
  logic            w_mis;
  logic [3:0]      w_be;
  logic [WORD-1:0] w_wdata;
  logic            w_stall;
  logic            w_mis_pulse;
  logic            w_accept;
  logic            w_complete;
  logic            w_abort;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [WORD-1:0] w_load;

  assign w_req = memRead | memWrite;

  // size 2'b11 falls into the word checks and lanes.
  always_comb begin
    w_mis   = 1'b0;
    w_be    = 4'b1111;
    w_wdata = writeData;
    case (size)
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{writeData[7:0]}};
      end
      2'b01: begin
        w_mis   = addr[0];
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{writeData[15:0]}};
      end
      default: begin
        w_mis   = (addr[1:0] != 2'b00);
        w_be    = 4'b1111;
        w_wdata = writeData;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_mis_pulse = 1'b0;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_mis) begin
            w_mis_pulse = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        // An ack on the last allowed cycle still counts as a normal completion.
        if (bus_ack) begin
          w_complete  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_half = r_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_lo)
      2'd0:    w_byte = bus_rdata[7:0];
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    case (r_size)
      2'b00:   w_load = r_uns ? {{(WORD-8){1'b0}}, w_byte}
                              : {{(WORD-8){w_byte[7]}}, w_byte};
      2'b01:   w_load = r_uns ? {{(WORD-16){1'b0}}, w_half}
                              : {{(WORD-16){w_half[15]}}, w_half};
      default: w_load = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= '0;
      r_read_data <= '0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
      r_lo        <= 2'b00;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= memWrite;
        r_bus_addr  <= {addr[WORD-1:2], 2'b00};
        r_bus_be    <= w_be;
        r_bus_wdata <= w_wdata;
        r_lo        <= addr[1:0];
        r_size      <= size;
        r_uns       <= unsignedLd;
        r_cnt       <= '0;
      end
      if (r_state == S_BUSY && !w_complete && !w_abort) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_complete) begin
        r_bus_req   <= 1'b0;
        r_read_data <= r_bus_we ? '0 : w_load;
      end
      if (w_abort) begin
        r_bus_req   <= 1'b0;
        r_timeout   <= 1'b1;
        r_read_data <= '0;
      end
    end
  end

  assign readData    = w_mis_pulse ? '0 : r_read_data;
  assign stall       = w_stall;
  assign misaligned  = w_mis_pulse;
  assign timeout     = r_timeout;
  assign bus_req     = r_bus_req;
  assign bus_we      = r_bus_we;
  assign bus_addr    = r_bus_addr;
  assign bus_be      = r_bus_be;
  assign bus_wdata   = r_bus_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: lane steering, load extension, misalignment,
// timeout, reset mid-access and back-to-back requests.
module tb_dmem_bridge;

  logic        clk;
  logic        rst_n;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  size;
  logic        unsignedLd;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        stall;
  logic        misaligned;
  logic        timeout;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [1:0]  o_dbg_state;

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_q[$];

  dmem_bridge #(.WORD(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .size(size), .unsignedLd(unsignedLd), .addr(addr), .writeData(writeData),
    .readData(readData), .stall(stall), .misaligned(misaligned), .timeout(timeout),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .o_dbg_state(o_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the bridge in IDLE; returns at the negedge after DONE.
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] rdata,
                        input logic [31:0] exp_rd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic exp_we,
                        input int exp_stall, input int exp_req, input logic exp_to);
    int          stall_n;
    int          req_n;
    logic        done;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic [31:0] cap_addr;
    logic        cap_we;
    stall_n = 0; req_n = 0; done = 1'b0;
    cap_be = 4'h0; cap_wdata = 32'h0; cap_addr = 32'h0; cap_we = 1'b0;
    memRead = rd; memWrite = wr; size = sz; unsignedLd = uns;
    addr = a; writeData = wd; bus_rdata = rdata; bus_ack = 1'b0;
    exp_q.push_back({a[31:2], 2'b00});
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      #1;
      if (stall) stall_n++;
      else if (cyc > 0) done = 1'b1;
      if (bus_req) begin
        req_n++;
        cap_be = bus_be; cap_wdata = bus_wdata; cap_addr = bus_addr; cap_we = bus_we;
        bus_ack = (req_n > waits);
      end else begin
        bus_ack = 1'b0;
      end
      if (!done) @(negedge clk);
    end
    check({name, ".done"}, {31'h0, done}, 32'h1);
    check({name, ".state"}, {30'h0, o_dbg_state}, 32'h2);
    check({name, ".readData"}, readData, exp_rd);
    check({name, ".timeout"}, {31'h0, timeout}, {31'h0, exp_to});
    check({name, ".stall_cycles"}, stall_n, exp_stall);
    check({name, ".req_cycles"}, req_n, exp_req);
    check({name, ".be"}, {28'h0, cap_be}, {28'h0, exp_be});
    check({name, ".we"}, {31'h0, cap_we}, {31'h0, exp_we});
    if (exp_we) check({name, ".wdata"}, cap_wdata, exp_wdata);
    if (exp_q.size() > 0) check({name, ".addr"}, cap_addr, exp_q.pop_front());
    @(negedge clk);
    memRead = 1'b0; memWrite = 1'b0; bus_ack = 1'b0;
  endtask

  task automatic mis_access(input string name, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] prev_rd);
    memRead = 1'b1; memWrite = 1'b0; size = sz; unsignedLd = 1'b0; addr = a;
    #1;
    check({name, ".misaligned"}, {31'h0, misaligned}, 32'h1);
    check({name, ".stall"}, {31'h0, stall}, 32'h0);
    check({name, ".readData"}, readData, 32'h0);
    @(negedge clk);
    memRead = 1'b0;
    #1;
    check({name, ".no_req"}, {31'h0, bus_req}, 32'h0);
    check({name, ".idle"}, {30'h0, o_dbg_state}, 32'h0);
    check({name, ".pulse_end"}, {31'h0, misaligned}, 32'h0);
    check({name, ".rd_hold"}, readData, prev_rd);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; size = 2'b00; unsignedLd = 1'b0;
    addr = 32'h0; writeData = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.bus_req", {31'h0, bus_req}, 32'h0);
    check("rst.stall", {31'h0, stall}, 32'h0);
    check("rst.readData", readData, 32'h0);
    check("rst.timeout", {31'h0, timeout}, 32'h0);
    check("rst.bus_be", {28'h0, bus_be}, 32'h0);
    check("rst.bus_addr", bus_addr, 32'h0);
    check("rst.bus_wdata", bus_wdata, 32'h0);
    check("rst.state", {30'h0, o_dbg_state}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // sw with two wait states
    access("sw104", 1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 2, 32'h0,
           32'h0, 4'b1111, 32'hDEADBEEF, 1'b1, 4, 3, 1'b0);
    access("lb103", 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h80FF7F01,
           32'hFFFFFF80, 4'b1000, 32'h0, 1'b0, 2, 1, 1'b0);
    access("lbu103", 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1, 32'h80FF7F01,
           32'h00000080, 4'b1000, 32'h0, 1'b0, 3, 2, 1'b0);
    access("lbu101", 1'b1, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 0, 32'h80FF7F01,
           32'h0000007F, 4'b0010, 32'h0, 1'b0, 2, 1, 1'b0);
    access("sb105", 1'b0, 1'b1, 2'b00, 1'b0, 32'h105, 32'h123456AB, 0, 32'h0,
           32'h0, 4'b0010, 32'hABABABAB, 1'b1, 2, 1, 1'b0);
    access("sh106", 1'b0, 1'b1, 2'b01, 1'b0, 32'h106, 32'h7777BEEF, 0, 32'h0,
           32'h0, 4'b1100, 32'hBEEFBEEF, 1'b1, 2, 1, 1'b0);
    access("lhu100", 1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 0, 32'h1234F00D,
           32'h0000F00D, 4'b0011, 32'h0, 1'b0, 2, 1, 1'b0);
    access("lw_sz11", 1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 0, 32'h55AA55AA,
           32'h55AA55AA, 4'b1111, 32'h0, 1'b0, 2, 1, 1'b0);
    access("lh102", 1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 32'h8001FFFF,
           32'hFFFF8001, 4'b1100, 32'h0, 1'b0, 2, 1, 1'b0);
    mis_access("sh101", 2'b01, 32'h101, 32'hFFFF8001);
    mis_access("lw106", 2'b10, 32'h106, 32'hFFFF8001);

    // ack on the last allowed BUSY cycle completes normally
    access("lw_ack63", 1'b1, 1'b0, 2'b10, 1'b0, 32'h1F0, 32'h0, 63, 32'h0BADF00D,
           32'h0BADF00D, 4'b1111, 32'h0, 1'b0, 65, 64, 1'b0);
    access("lw_tmo", 1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1000, 32'hFFFFFFFF,
           32'h0, 4'b1111, 32'h0, 1'b0, 65, 64, 1'b1);
    access("lw_after", 1'b1, 1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 0, 32'h12345678,
           32'h12345678, 4'b1111, 32'h0, 1'b0, 2, 1, 1'b1);

    // reset while BUSY, then a stray ack
    memRead = 1'b1; size = 2'b10; addr = 32'h300;
    @(negedge clk);
    #1;
    check("rstbusy.req_before", {31'h0, bus_req}, 32'h1);
    rst_n = 1'b0; memRead = 1'b0;
    @(negedge clk);
    #1;
    check("rstbusy.req_after", {31'h0, bus_req}, 32'h0);
    check("rstbusy.state", {30'h0, o_dbg_state}, 32'h0);
    check("rstbusy.readData", readData, 32'h0);
    check("rstbusy.timeout_clr", {31'h0, timeout}, 32'h0);
    rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("rstack.req", {31'h0, bus_req}, 32'h0);
    check("rstack.state", {30'h0, o_dbg_state}, 32'h0);
    check("rstack.readData", readData, 32'h0);
    check("rstack.stall", {31'h0, stall}, 32'h0);
    @(negedge clk);

    // read+write together acts as a write; then back-to-back sw/lw
    access("rw8", 1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h11112222, 0, 32'h0,
           32'h0, 4'b1111, 32'h11112222, 1'b1, 2, 1, 1'b0);
    access("b2b_sw", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, 1, 32'h0,
           32'h0, 4'b1111, 32'hCAFEF00D, 1'b1, 3, 2, 1'b0);
    access("b2b_lw", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 32'hCAFEF00D,
           32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 2, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("idle.req", {31'h0, bus_req}, 32'h0);
      check("idle.stall", {31'h0, stall}, 32'h0);
      check("idle.rd_hold", readData, 32'hCAFEF00D);
      @(negedge clk);
    end
    check("exp_q_empty", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
